// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: modes, register map, STATUS layout, FSM states.
package led_seq_pkg;

   localparam int unsigned ADDR_W = 2;

   localparam logic [1:0] MODE_STATIC = 2'd0;
   localparam logic [1:0] MODE_BLINK  = 2'd1;
   localparam logic [1:0] MODE_SEQ    = 2'd2;

   localparam logic [ADDR_W-1:0] ADDR_CTRL    = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_PERIOD  = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_PATTERN = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_DUTY    = 2'd3;

   localparam int unsigned STAT_DUTY_LSB = 0;
   localparam int unsigned STAT_STEP_LSB = 8;
   localparam int unsigned STAT_DONE_BIT = 10;
   localparam int unsigned STAT_RAW_LSB  = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   // Select one 4-bit step out of the packed PATTERN word.
   function automatic logic [3:0] pattern_step(input logic [15:0] pat, input logic [1:0] idx);
      return pat[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/led_pwm.sv
// Global brightness stage: free-running counter compared against the duty value.
module led_pwm #(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PWM_BITS-1:0] duty_i,
   output logic                on_c
);

   logic [PWM_BITS-1:0] cnt_q;

   // Free-running brightness counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_q + PWM_BITS'(1);
   end

   // All-ones duty means fully on; otherwise high for duty counts out of 2^PWM_BITS.
   assign on_c = (duty_i == '1) || (cnt_q < duty_i);

endmodule

// File: rtl/led_sequencer.sv
// Memory-mapped 4-LED controller: static / blink / timed pattern sequence.
// Optional PWM brightness stage enabled by defining LED_PWM_EN.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned PRESCALE = 1000,
   parameter int unsigned PWM_BITS = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rstrb,
   input  logic        wstrb,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [3:0]  LED
);

   localparam int unsigned   CW        = 16;
   localparam logic [CW-1:0] PRESC_MAX = CW'(PRESCALE - 1);

   seq_state_e    state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [1:0]    len_q, len_d;
   logic          one_shot_q, one_shot_d;
   logic [3:0]    value_q, value_d;
   logic [CW-1:0] period_q, period_d;
   logic [15:0]   pattern_q, pattern_d;
   logic [1:0]    step_q, step_d;
   logic          phase_q, phase_d;
   logic          done_q, done_d;
   logic [CW-1:0] presc_q, presc_d;
   logic [CW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    raw_q, raw_d;
   logic [3:0]    led_q, led_d;
   logic [7:0]    duty8;

   logic          wr, wr_ctrl, rd_stat, tick, expire;
   logic [CW-1:0] period_eff;
   logic          unused_wdata;

   assign wr         = sel && wstrb;
   assign wr_ctrl    = wr && (addr == ADDR_CTRL);
   assign rd_stat    = sel && rstrb && (addr == ADDR_DUTY);
   assign tick       = (presc_q == PRESC_MAX);
   assign period_eff = (period_q == '0) ? CW'(1) : period_q;
   assign expire     = tick && (tcnt_q >= period_eff - CW'(1));
   assign unused_wdata = ^{wdata[31:16], wdata[7:5]};

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                pwm_on_c;

   led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk    (clk),
      .rst_n  (resetn),
      .duty_i (duty_q),
      .on_c   (pwm_on_c)
   );

   assign duty8 = 8'(duty_q);
`else
   assign duty8 = 8'h00;
`endif

   // State and register file.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         mode_q     <= MODE_STATIC;
         len_q      <= 2'd0;
         one_shot_q <= 1'b0;
         value_q    <= 4'h0;
         period_q   <= CW'(1);
         pattern_q  <= 16'h0000;
         step_q     <= 2'd0;
         phase_q    <= 1'b1;
         done_q     <= 1'b0;
         presc_q    <= '0;
         tcnt_q     <= '0;
         raw_q      <= 4'h0;
         led_q      <= 4'h0;
`ifdef LED_PWM_EN
         duty_q     <= '1;
`endif
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         len_q      <= len_d;
         one_shot_q <= one_shot_d;
         value_q    <= value_d;
         period_q   <= period_d;
         pattern_q  <= pattern_d;
         step_q     <= step_d;
         phase_q    <= phase_d;
         done_q     <= done_d;
         presc_q    <= presc_d;
         tcnt_q     <= tcnt_d;
         raw_q      <= raw_d;
         led_q      <= led_d;
`ifdef LED_PWM_EN
         duty_q     <= duty_d;
`endif
      end
   end

   // Next-state: counters, bus writes, sequencer steps; a CTRL write overrides all.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      len_d      = len_q;
      one_shot_d = one_shot_q;
      value_d    = value_q;
      period_d   = period_q;
      pattern_d  = pattern_q;
      step_d     = step_q;
      phase_d    = phase_q;
      done_d     = done_q;
      raw_d      = raw_q;
      presc_d    = tick ? '0 : presc_q + CW'(1);
      tcnt_d     = expire ? '0 : (tick ? tcnt_q + CW'(1) : tcnt_q);
`ifdef LED_PWM_EN
      duty_d     = duty_q;
      if (wr && (addr == ADDR_DUTY)) duty_d = wdata[PWM_BITS-1:0];
      led_d      = raw_q & {4{pwm_on_c}};
`else
      led_d      = raw_q;
`endif

      if (rd_stat) done_d = 1'b0;
      if (wr && (addr == ADDR_PERIOD))  period_d  = wdata[15:0];
      if (wr && (addr == ADDR_PATTERN)) pattern_d = wdata[15:0];

      case (state_q)
         RUN: begin
            if (expire) begin
               if (mode_q == MODE_BLINK) begin
                  phase_d = ~phase_q;
               end else if (step_q == len_q) begin
                  if (one_shot_q) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     step_d = 2'd0;
                  end
               end else begin
                  step_d = step_q + 2'd1;
               end
            end
         end
         default: ;
      endcase

      if (wr_ctrl) begin
         mode_d     = wdata[1:0];
         len_d      = wdata[3:2];
         one_shot_d = wdata[4];
         value_d    = wdata[11:8];
         presc_d    = '0;
         tcnt_d     = '0;
         step_d     = 2'd0;
         phase_d    = 1'b1;
         done_d     = 1'b0;
         state_d    = ((wdata[1:0] == MODE_BLINK) || (wdata[1:0] == MODE_SEQ)) ? RUN : IDLE;
      end

      case (state_d)
         IDLE:    raw_d = value_d;
         RUN:     raw_d = (mode_d == MODE_BLINK) ? (phase_d ? value_d : 4'h0)
                                                 : pattern_step(pattern_d, step_d);
         default: raw_d = raw_q;
      endcase
   end

   // Combinational read mux.
   always_comb begin
      rdata = 32'h0;
      if (sel) begin
         case (addr)
            ADDR_CTRL:    rdata = {20'b0, value_q, 3'b0, one_shot_q, len_q, mode_q};
            ADDR_PERIOD:  rdata = {16'b0, period_q};
            ADDR_PATTERN: rdata = {16'b0, pattern_q};
            default: begin
               rdata[STAT_RAW_LSB +: 4]  = raw_q;
               rdata[STAT_DONE_BIT]      = done_q;
               rdata[STAT_STEP_LSB +: 2] = step_q;
               rdata[STAT_DUTY_LSB +: 8] = duty8;
            end
         endcase
      end
   end

   assign LED = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (PRESCALE=4); closed-form timing model.
module tb_led_sequencer;
   import led_seq_pkg::*;

   localparam int unsigned PRESC = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        rstrb = 1'b0;
   logic        wstrb = 1'b0;
   logic        sel = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic [3:0]  LED;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;

   // Reference model: configuration plus the cycle of the last CTRL write.
   logic [1:0]  m_mode;
   logic [3:0]  m_val;
   int unsigned m_len;
   logic        m_os;
   int unsigned m_period;
   logic [15:0] m_pat;
   logic [7:0]  m_duty;
   int unsigned e0;
   logic        cleared;

   led_sequencer #(.PRESCALE(PRESC), .PWM_BITS(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .rstrb  (rstrb),
      .wstrb  (wstrb),
      .sel    (sel),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .LED    (LED)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned steps_done(input int unsigned n);
      return n / (PRESC * ((m_period == 0) ? 1 : m_period));
   endfunction

   function automatic int unsigned step_at(input int unsigned n);
      int unsigned s;
      s = steps_done(n);
      if (m_mode != 2'd2) return 0;
      if (m_os && (s >= m_len)) return m_len - 1;
      return s % m_len;
   endfunction

   function automatic logic [3:0] raw_at(input int unsigned n);
      if (m_mode == 2'd1) return ((steps_done(n) % 2) == 0) ? m_val : 4'h0;
      if (m_mode == 2'd2) return 4'(m_pat >> (4 * step_at(n)));
      return m_val;
   endfunction

   function automatic logic done_reached(input int unsigned n);
      return (m_mode == 2'd2) && m_os && (steps_done(n) >= m_len);
   endfunction

   task automatic model_reset();
      m_mode = 2'd0; m_val = 4'h0; m_len = 1; m_os = 1'b0;
      m_period = 1; m_pat = 16'h0; cleared = 1'b0; e0 = cyc;
`ifdef LED_PWM_EN
      m_duty = 8'hFF;
`else
      m_duty = 8'h00;
`endif
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Caller sits at a negedge; the write lands on the following posedge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wstrb = 1'b0;
      if (a == ADDR_CTRL) begin
         m_mode = d[1:0]; m_len = 32'(d[3:2]) + 1; m_os = d[4]; m_val = d[11:8];
         e0 = cyc; cleared = 1'b0;
      end else if (a == ADDR_PERIOD) begin
         m_period = 32'(d[15:0]);
      end else if (a == ADDR_PATTERN) begin
         m_pat = d[15:0];
      end else begin
`ifdef LED_PWM_EN
         m_duty = d[7:0];
`endif
      end
   endtask

   task automatic bus_read_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
      sel = 1'b1; rstrb = 1'b1; addr = a;
      #1;
      chk(tag, rdata, exp);
      @(negedge clk);
      sel = 1'b0; rstrb = 1'b0;
   endtask

   task automatic check_status(input string tag);
      int unsigned n;
      logic        dv;
      logic [31:0] e;
      sel = 1'b1; rstrb = 1'b1; addr = ADDR_DUTY;
      #1;
      n  = cyc - e0;
      dv = done_reached(n) && !cleared;
      e  = {16'b0, raw_at(n), 1'b0, dv, 2'(step_at(n)), m_duty};
      chk(tag, rdata, e);
      if (dv) cleared = 1'b1;
      @(negedge clk);
      sel = 1'b0; rstrb = 1'b0;
   endtask

   task automatic check_led(input int unsigned cnt, input string tag);
      int unsigned n;
      for (int i = 0; i < int'(cnt); i++) begin
         @(negedge clk);
         n = cyc - e0;
         if (n >= 1) chk(tag, 32'(LED), 32'(raw_at(n - 1)));
      end
   endtask

   task automatic count_on(output int unsigned on, output int unsigned bad);
      on = 0; bad = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (LED === 4'hF) on++;
         else if (LED !== 4'h0) bad++;
      end
   endtask

   initial begin
      logic [31:0]  w;
      logic [1:0]   r_mode, r_lm1;
      logic [3:0]   r_val;
      logic         r_os;
      int unsigned  on, bad;

      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_led_held", 32'(LED), 32'h0);
      resetn = 1'b1;
      model_reset();
      chk("rdata_unsel", rdata, 32'h0);
      check_status("rst_status");
      bus_read_chk(ADDR_PERIOD, 32'h1, "rst_period");
      bus_read_chk(ADDR_CTRL, 32'h0, "rst_ctrl");
      bus_read_chk(ADDR_PATTERN, 32'h0, "rst_pattern");
      check_led(3, "rst_led");

      // Static value.
      bus_write(ADDR_CTRL, 32'h0000_0A00);
      check_led(100, "static");
      bus_read_chk(ADDR_CTRL, 32'h0000_0A00, "static_ctrl_rb");

      // Blink, 8 cycles per phase.
      bus_write(ADDR_PERIOD, 32'h2);
      bus_write(ADDR_CTRL, 32'h0000_0F01);
      check_led(48, "blink");

      // One-shot 4-step sequence, then done clear on read.
      bus_write(ADDR_PATTERN, 32'h8421);
      bus_write(ADDR_PERIOD, 32'h1);
      bus_write(ADDR_CTRL, 32'h0000_001E);
      check_led(24, "seq_oneshot");
      check_status("seq_done_set");
      check_status("seq_done_clr");

      // CTRL write colliding with a tick mid-sequence.
      bus_write(ADDR_PERIOD, 32'h2);
      bus_write(ADDR_CTRL, 32'h0000_001E);
      check_led(10, "coll_pre");
      for (int k = 0; (k < 8) && (((cyc - e0) % PRESC) != PRESC - 1); k++) @(negedge clk);
      chk("coll_align", (cyc - e0) % PRESC, PRESC - 1);
      bus_write(ADDR_CTRL, 32'h0000_001E);
      check_status("coll_status");
      check_led(40, "coll_post");

      // Randomized configurations.
      for (int r = 0; r < 8; r++) begin
         r_mode = 2'($urandom_range(0, 3));
         r_lm1  = 2'($urandom_range(0, 3));
         r_val  = 4'($urandom_range(0, 15));
         r_os   = 1'($urandom_range(0, 1));
         w = $urandom; w[15:0] = 16'($urandom);
         bus_write(ADDR_PATTERN, w);
         w = $urandom; w[15:0] = 16'($urandom_range(0, 3));
         bus_write(ADDR_PERIOD, w);
         w = $urandom;
         w[11:8] = r_val; w[4] = r_os; w[3:2] = r_lm1; w[1:0] = r_mode;
         bus_write(ADDR_CTRL, w);
         check_led(60, "rand_led_a");
         check_status("rand_status_a");
         check_led(40, "rand_led_b");
         check_status("rand_status_b");
         bus_read_chk(ADDR_CTRL, {20'b0, m_val, 3'b0, m_os, 2'(m_len - 1), m_mode}, "rand_ctrl_rb");
         bus_read_chk(ADDR_PERIOD, m_period, "rand_period_rb");
         bus_read_chk(ADDR_PATTERN, {16'b0, m_pat}, "rand_pattern_rb");
      end

      // Reset asserted mid-step.
      bus_write(ADDR_PATTERN, 32'hF731);
      bus_write(ADDR_PERIOD, 32'h3);
      bus_write(ADDR_CTRL, 32'h0000_050E);
      check_led(17, "pre_reset");
      resetn = 1'b0;
      #1;
      chk("async_reset_led", 32'(LED), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
      bus_read_chk(ADDR_PERIOD, 32'h1, "post_reset_period");
      bus_read_chk(ADDR_PATTERN, 32'h0, "post_reset_pattern");
      check_status("post_reset_status");
      check_led(20, "post_reset_led");

`ifdef LED_PWM_EN
      bus_write(ADDR_CTRL, 32'h0000_0F00);
      bus_write(ADDR_DUTY, 32'd64);
      repeat (4) @(negedge clk);
      count_on(on, bad);
      chk("pwm64_on", on, 32'd64);
      chk("pwm64_bad", bad, 32'd0);
      check_status("pwm64_status");
      bus_write(ADDR_DUTY, 32'd0);
      repeat (4) @(negedge clk);
      count_on(on, bad);
      chk("pwm0_on", on, 32'd0);
      chk("pwm0_bad", bad, 32'd0);
      bus_write(ADDR_DUTY, 32'd255);
      repeat (4) @(negedge clk);
      count_on(on, bad);
      chk("pwm255_on", on, 32'd256);
      check_status("pwm255_status");
`else
      bus_write(ADDR_CTRL, 32'h0000_0F00);
      bus_write(ADDR_DUTY, 32'd64);
      check_status("nopwm_status");
      check_led(10, "nopwm_led");
      count_on(on, bad);
      chk("nopwm_on", on, 32'd256);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Memory-mapped LED controller on the CPU I/O bus. It replaces the plain 4-bit LED latch with a small scheduler that drives the 4 LED pins in one of three modes: static value, blink, or a timed pattern sequence of up to 4 steps. An optional global PWM brightness stage sits on the output. It uses the same select/strobe bus as the other I/O peripherals and adds a 2-bit word address.

## Interface
Parameters:
- PRESCALE, default 1000: clk cycles per sequencer tick; legal range 1..65535.
- PWM_BITS, default 8: width of the brightness counter and the DUTY field.

Ports (clock and reset first):
- clk  in  1  system clock; every register updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rstrb  in  1  read strobe.
- wstrb  in  1  write strobe.
- sel  in  1  block select; reads and writes are ignored when it is low.
- addr  in  2  word select: 0 CTRL, 1 PERIOD, 2 PATTERN, 3 DUTY/STATUS.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational; 32'b0 when sel is low.
- LED  out  4  LED pins.

## Operation
Registers (written when sel && wstrb):
- CTRL:
  - [1:0] mode: 0 STATIC, 1 BLINK, 2 SEQ; 3 behaves as STATIC.
  - [3:2] seq_len−1.
  - [4] one_shot.
  - [11:8] value (STATIC output, or BLINK mask).
  - Reads back {20'b0, value, 3'b0, one_shot, seq_len−1, mode}.
- PERIOD:
  - [15:0] step period in ticks.
  - 0 is treated as 1.
  - Reads back the stored value.
- PATTERN:
  - [15:0] holds four 4-bit steps; step n is bits [4n+3:4n].
  - Reads back the stored value.
- DUTY/STATUS:
  - Write: [PWM_BITS−1:0] sets duty.
  - Read: {16'b0, raw[3:0], 1'b0, done, step[1:0], duty[7:0]}.
  - A read (sel && rstrb && addr==3) clears done on the next edge.

Sequencer states:
- IDLE (STATIC): raw = value.
- RUN:
  - BLINK: a phase bit toggles each period expiry; raw = phase ? mask : 4'b0.
  - SEQ: raw = PATTERN step[step]. On period expiry, step increments. After step reaches seq_len−1:
    - one_shot=0: step wraps to 0.
    - one_shot=1: move to DONE.
- DONE: raw holds the last step and done=1. Only a CTRL write leaves DONE.

Restart: any CTRL write, in any state, does all of the following on that edge:
- clears prescaler, tick counter and step;
- sets phase=1 and done=0;
- enters IDLE or RUN according to the new mode.

Writes to PERIOD and PATTERN take effect at the next comparison and do not restart the sequencer.

## Timing
Reset values:
- LED=0, raw=0, mode=STATIC, value=0, one_shot=0, seq_len−1=0.
- PERIOD=1, PATTERN=0, duty=all ones, step=0, phase=1, done=0, all counters 0.

Counters:
- The prescaler counts 0..PRESCALE−1. A 1-cycle tick pulse fires on wrap.
- The tick counter counts ticks. It expires when it equals PERIOD−1 at a tick, then clears.
- One step lasts PRESCALE×PERIOD cycles.

Latency:
- From a CTRL write edge: new raw is visible the cycle after the edge, and LED follows with 1 more cycle (registered output).
- First expiry occurs PRESCALE×PERIOD cycles after the write.

Simultaneous events:
- CTRL write in the same cycle as a tick: the write wins and the tick is discarded.
- done set and status-read clear in the same cycle: set wins.
- Reset asserted mid-step: everything returns to reset values immediately, with no partial step.

rdata depends only on sel, addr and the register state; rstrb does not gate it.

## Configuration
- LED_PWM_EN defined:
  - A free-running PWM_BITS counter runs on clk.
  - LED = raw & {4{cnt < duty}}.
  - duty=all ones forces full on; duty=0 forces off.
- LED_PWM_EN undefined:
  - LED = raw, registered.
  - DUTY writes are ignored and the STATUS duty field reads 0.

## Structure
- Package led_seq_pkg holds:
  - the mode encodings (MODE_STATIC, MODE_BLINK, MODE_SEQ);
  - the register address constants (ADDR_CTRL, ADDR_PERIOD, ADDR_PATTERN, ADDR_DUTY);
  - the STATUS bit positions;
  - the sequencer state enum (IDLE, RUN, DONE).
- One sub-module: led_pwm. It holds the PWM counter and compare, and is instantiated only under LED_PWM_EN.

## Test plan
Bench uses PRESCALE=4.
- Reset: deassert resetn → LED=0, STATUS read = 0x000000FF (PWM_EN) or 0x00000000 (no PWM_EN); PERIOD reads 1.
- STATIC: write CTRL=0x0000_0A00 → LED=4'b1010 two cycles after the write edge and constant for 100 cycles.
- BLINK: PERIOD=2, CTRL=0x0000_0F01 → LED=4'hF for 8 cycles, 0 for 8, 4'hF for 8, and repeats.
- SEQ one-shot:
  - Setup: PATTERN=0x8421, PERIOD=1, CTRL=0x0000_001E. This is mode 2, seq_len 4, one_shot=1.
  - LED shows 1, 2, 4, 8 with 4 cycles each, then holds 8; STATUS done=1, step=3.
  - A STATUS read clears done; the next read returns done=0.
- Restart collision: issue a CTRL write on the exact cycle a tick fires mid-sequence → step=0, done=0, and the first expiry occurs 4×PERIOD cycles after the write.
- PWM (LED_PWM_EN): static 4'hF, duty=64 → each LED is high exactly 64 of every 256 cycles; duty=0 → always 0; duty=255 → always 4'hF.
